alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: ALU_LAT, default 1, number of cycles the shared combinational ALU is given to settle before capture (legal 1..7).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester N's operation accepted this cycle when valid&ready.
REQ-006 req0_op / req1_op  input  2 each  ALU opcode from requester N.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  3 each  sign-magnitude operands (bit 2 = sign) from requester N.
REQ-008 alu_op  output  2  registered opcode driven to the shared ALU.
REQ-009 alu_a, alu_b  output  3 each  registered operands driven to the shared ALU.
REQ-010 alu_res  input  4  shared ALU result.
REQ-011 alu_zerf, alu_negf, alu_dzf  input  1 each  shared ALU zero, negative and divide-by-zero flags.
REQ-012 rsp0_valid / rsp1_valid  output  1 each  one-cycle pulse: response for requester N is on rsp_res/rsp_flags.
REQ-013 rsp_res  output  4  captured result.
REQ-014 rsp_flags  output  3  captured flags, {dzf, negf, zerf}.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, DONE; IDLE->ISSUE on any handshake, ISSUE->DONE after ALU_LAT cycles, DONE->IDLE unconditionally.
REQ-017 Ready only in IDLE; only valid requester -> granted; both valid -> requester selected by round-robin pointer granted; neither valid -> both ready low.
REQ-018 req0_ready and req1_ready never high in the same cycle.
REQ-019 Pointer flips to the non-granted requester on every handshake; unchanged otherwise.
REQ-020 On handshake edge, alu_op/alu_a/alu_b load granted requester's op/a/b; owner register records granted index.
REQ-021 alu_op/alu_a/alu_b hold their values through ISSUE, DONE and IDLE until the next handshake; requester input changes have no effect.
REQ-022 3-bit settle counter loads ALU_LAT-1 on entry to ISSUE, decrements each ISSUE cycle; capture edge is the ISSUE edge where counter equals 0.
REQ-023 Capture edge: rsp_res <= alu_res, rsp_flags <= {alu_dzf, alu_negf, alu_zerf}; if alu_dzf = 1, rsp_res <= 4'b0000 and rsp_flags <= 3'b101 regardless of other inputs.
REQ-024 rspN_valid high only in DONE, only for owner N; exactly ALU_LAT+1 cycles after the handshake edge.
REQ-025 rsp_res/rsp_flags hold between captures; no response backpressure.
REQ-026 Minimum handshake-to-handshake spacing ALU_LAT+2 cycles; a requester held valid is re-accepted in the first IDLE cycle it wins.

Reset
REQ-027 rst high immediately forces: state IDLE, pointer = requester 0, owner 0, counter 0, alu_op/alu_a/alu_b 0, rsp_res 0, rsp_flags 0, rsp0/1_valid 0, busy 0.
REQ-028 rst during ISSUE or DONE aborts the operation; no response pulse issued for it after release.
REQ-029 First edge after rst release with requester valid performs a normal handshake.

Verification
REQ-030 ALU_LAT=1, only req0_valid, op=3, a=3'b011, b=3'b010, alu_res=4'b0001 -> req0_ready at cycle 0, alu_a=3'b011 from cycle 1, rsp0_valid cycle 2, rsp_res=4'b0001, rsp_flags=3'b000.
REQ-031 Both valid continuously after reset -> grants alternate req0, req1, req0, req1; handshakes every 3 cycles; never both ready.
REQ-032 alu_dzf=1, alu_res=4'b1001, alu_negf=1 at capture -> rsp_res=4'b0000, rsp_flags=3'b101.
REQ-033 ALU_LAT=3, req1 handshake; req1_a changed during ISSUE -> alu_a unchanged, rsp1_valid exactly 4 cycles after handshake.
REQ-034 rst asserted mid-ISSUE with req1 owner -> all outputs 0 at once; no rsp1_valid after release; next contention grants req0 first.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Purpose: bundles the two requester ports, the shared-ALU drive/return
//          signals and the response bus of alu_share_arb.
// Ports:   slave = arbiter side, master = requesters + ALU + response sink.
interface alu_share_arb_if;
  // requester 0
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [2:0] req0_a;
  logic [2:0] req0_b;
  // requester 1
  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [2:0] req1_a;
  logic [2:0] req1_b;
  // shared combinational ALU
  logic [1:0] alu_op;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zerf;
  logic       alu_negf;
  logic       alu_dzf;
  // response
  logic       rsp0_valid;
  logic       rsp1_valid;
  logic [3:0] rsp_res;
  logic [2:0] rsp_flags;
  logic       busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_res, alu_zerf, alu_negf, alu_dzf,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp0_valid, rsp1_valid, rsp_res, rsp_flags, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_res, alu_zerf, alu_negf, alu_dzf,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp0_valid, rsp1_valid, rsp_res, rsp_flags, busy
  );
endinterface

// File: rtl/alu_share_arb.sv
// Purpose: round-robin arbiter sharing one combinational ALU between two
//          requesters; issues operands, waits ALU_LAT cycles, captures result.
// Latency: response pulse ALU_LAT+1 cycles after the accepting edge; next
//          accept no sooner than ALU_LAT+2 cycles after the previous one.
// Backpressure: ready only while IDLE; responses cannot be stalled.
// Ports:   clk, rst (async, active-high); bus (alu_share_arb_if.slave) carries
//          req0/req1 valid/ready/op/a/b, alu_op/a/b out, alu_res + flags in,
//          rsp0/rsp1_valid, rsp_res, rsp_flags {dzf,negf,zerf}, busy.
module alu_share_arb #(
  parameter int unsigned ALU_LAT = 1  // ALU settle cycles, legal 1..7
) (
  input  logic           clk,
  input  logic           rst,
  alu_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] SETTLE_INIT = 3'(ALU_LAT - 1);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;        // requester that wins the next contention
  logic       owner_q, owner_d;    // requester owning the operation in flight
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic [2:0] alu_a_q, alu_a_d;
  logic [2:0] alu_b_q, alu_b_d;
  logic [3:0] rsp_res_q, rsp_res_d;
  logic [2:0] rsp_flags_q, rsp_flags_d;
  logic       rsp0_valid_q, rsp0_valid_d;
  logic       rsp1_valid_q, rsp1_valid_d;
  logic       busy_q, busy_d;

  logic       idle;
  logic       grant0;
  logic       grant1;
  logic       hs;

  // Grants are one-hot by construction: on contention only the pointer's
  // requester sees ready.
  always_comb begin
    idle   = (state_q == IDLE);
    grant0 = idle & bus.req0_valid & (~bus.req1_valid | ~ptr_q);
    grant1 = idle & bus.req1_valid & (~bus.req0_valid |  ptr_q);
    hs     = grant0 | grant1;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_res_d    = rsp_res_q;
    rsp_flags_d  = rsp_flags_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = ISSUE;
          cnt_d   = SETTLE_INIT;
          // Pointer moves to the requester that just lost (or was absent).
          ptr_d   = grant0;
          owner_d = grant1;
          if (grant1) begin
            alu_op_d = bus.req1_op;
            alu_a_d  = bus.req1_a;
            alu_b_d  = bus.req1_b;
          end else begin
            alu_op_d = bus.req0_op;
            alu_a_d  = bus.req0_a;
            alu_b_d  = bus.req0_b;
          end
        end
      end

      ISSUE: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          // Divide-by-zero overrides whatever the ALU drives on res/flags.
          if (bus.alu_dzf) begin
            rsp_res_d   = 4'b0000;
            rsp_flags_d = 3'b101;
          end else begin
            rsp_res_d   = bus.alu_res;
            rsp_flags_d = {bus.alu_dzf, bus.alu_negf, bus.alu_zerf};
          end
          rsp0_valid_d = ~owner_q;
          rsp1_valid_d =  owner_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      cnt_q        <= 3'd0;
      alu_op_q     <= 2'd0;
      alu_a_q      <= 3'd0;
      alu_b_q      <= 3'd0;
      rsp_res_q    <= 4'd0;
      rsp_flags_q  <= 3'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_res_q    <= rsp_res_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_res    = rsp_res_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Purpose: directed checks of alu_share_arb at ALU_LAT=1 (u_a) and ALU_LAT=3 (u_b).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_alu_share_arb;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  alu_share_arb_if ifa();
  alu_share_arb_if ifb();

  alu_share_arb #(.ALU_LAT(1)) u_a (.clk(clk), .rst(rst_a), .bus(ifa));
  alu_share_arb #(.ALU_LAT(3)) u_b (.clk(clk), .rst(rst_b), .bus(ifb));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated LAT=1 operation on u_a; starts and ends at posedge+1 with u_a idle.
  task automatic run_op_a(input logic sel, input logic [1:0] op, input logic [2:0] a,
                          input logic [2:0] b, input logic [3:0] res, input logic z,
                          input logic n, input logic d, input logic [3:0] eres,
                          input logic [2:0] eflags, input string tag);
    logic [1:0] onehot;
    onehot = sel ? 2'b10 : 2'b01;
    if (sel) begin
      ifa.req1_valid = 1'b1; ifa.req1_op = op; ifa.req1_a = a; ifa.req1_b = b;
    end else begin
      ifa.req0_valid = 1'b1; ifa.req0_op = op; ifa.req0_a = a; ifa.req0_b = b;
    end
    @(negedge clk);
    check_val({tag, "_ready"}, 32'({ifa.req1_ready, ifa.req0_ready}), 32'(onehot));
    tick();
    // Requester inputs wiggle after acceptance; ALU returns its answer.
    ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
    ifa.req0_a = ~a; ifa.req1_a = ~a; ifa.req0_b = ~b; ifa.req1_b = ~b;
    ifa.alu_res = res; ifa.alu_zerf = z; ifa.alu_negf = n; ifa.alu_dzf = d;
    @(negedge clk);
    check_val({tag, "_alu"}, 32'({ifa.alu_op, ifa.alu_a, ifa.alu_b}), 32'({op, a, b}));
    check_val({tag, "_busy"}, 32'(ifa.busy), 32'd1);
    check_val({tag, "_early_rsp"}, 32'({ifa.rsp1_valid, ifa.rsp0_valid}), 32'd0);
    tick();
    @(negedge clk);
    check_val({tag, "_rsp_vld"}, 32'({ifa.rsp1_valid, ifa.rsp0_valid}), 32'(onehot));
    check_val({tag, "_rsp"}, 32'({ifa.rsp_res, ifa.rsp_flags}), 32'({eres, eflags}));
    tick();
    @(negedge clk);
    check_val({tag, "_end"}, 32'({ifa.busy, ifa.rsp1_valid, ifa.rsp0_valid}), 32'd0);
    check_val({tag, "_hold"}, 32'({ifa.rsp_res, ifa.rsp_flags, ifa.alu_a}), 32'({eres, eflags, a}));
    tick();
  endtask

  initial begin
    int pulses;
    logic [1:0] exp2;

    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.req0_valid = 1'b0; ifa.req0_op = 2'd0; ifa.req0_a = 3'd0; ifa.req0_b = 3'd0;
    ifa.req1_valid = 1'b0; ifa.req1_op = 2'd0; ifa.req1_a = 3'd0; ifa.req1_b = 3'd0;
    ifa.alu_res = 4'd0; ifa.alu_zerf = 1'b0; ifa.alu_negf = 1'b0; ifa.alu_dzf = 1'b0;
    ifb.req0_valid = 1'b0; ifb.req0_op = 2'd0; ifb.req0_a = 3'd0; ifb.req0_b = 3'd0;
    ifb.req1_valid = 1'b0; ifb.req1_op = 2'd0; ifb.req1_a = 3'd0; ifb.req1_b = 3'd0;
    ifb.alu_res = 4'd0; ifb.alu_zerf = 1'b0; ifb.alu_negf = 1'b0; ifb.alu_dzf = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk);
    check_val("rst_a_outs", 32'({ifa.busy, ifa.rsp1_valid, ifa.rsp0_valid, ifa.alu_op,
                                 ifa.alu_a, ifa.alu_b, ifa.rsp_res, ifa.rsp_flags}), 32'd0);
    check_val("rst_b_outs", 32'({ifb.busy, ifb.rsp1_valid, ifb.rsp0_valid, ifb.alu_op,
                                 ifb.alu_a, ifb.alu_b, ifb.rsp_res, ifb.rsp_flags}), 32'd0);
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // LAT=1 single operations
    run_op_a(1'b0, 2'd3, 3'b011, 3'b010, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 3'b000, "basic");
    run_op_a(1'b1, 2'd2, 3'b101, 3'b000, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b101, "div0");
    run_op_a(1'b0, 2'd0, 3'b001, 3'b101, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 3'b001, "zero");
    run_op_a(1'b1, 2'd1, 3'b010, 3'b110, 4'b1100, 1'b0, 1'b1, 1'b0, 4'b1100, 3'b010, "neg");

    // Round robin with both requesters held valid from reset release
    rst_a = 1'b1;
    ifa.req0_valid = 1'b1; ifa.req0_op = 2'd1; ifa.req0_a = 3'b001; ifa.req0_b = 3'b010;
    ifa.req1_valid = 1'b1; ifa.req1_op = 2'd2; ifa.req1_a = 3'b100; ifa.req1_b = 3'b011;
    ifa.alu_res = 4'b0111; ifa.alu_zerf = 1'b0; ifa.alu_negf = 1'b0; ifa.alu_dzf = 1'b0;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp2 = ((i / 3) % 2 == 1) ? 2'b10 : 2'b01;
      check_val($sformatf("rr_ready_c%0d", i), 32'({ifa.req1_ready, ifa.req0_ready}),
                32'((i % 3 == 0) ? exp2 : 2'b00));
      check_val($sformatf("rr_rsp_c%0d", i), 32'({ifa.rsp1_valid, ifa.rsp0_valid}),
                32'((i % 3 == 2) ? exp2 : 2'b00));
      if (i % 3 == 1)
        check_val($sformatf("rr_alu_a_c%0d", i), 32'(ifa.alu_a),
                  32'(((i / 3) % 2 == 1) ? 3'b100 : 3'b001));
      tick();
    end
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    repeat (3) tick();

    // LAT=3: req1 operands change during ISSUE; response 4 cycles after handshake
    ifb.req1_valid = 1'b1; ifb.req1_op = 2'd1; ifb.req1_a = 3'b110; ifb.req1_b = 3'b001;
    @(negedge clk);
    check_val("lat3_ready", 32'({ifb.req1_ready, ifb.req0_ready}), 32'd2);
    tick();
    ifb.req1_valid = 1'b0; ifb.req1_a = 3'b011; ifb.req1_b = 3'b111; ifb.req1_op = 2'd3;
    ifb.alu_res = 4'b0110; ifb.alu_negf = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_val($sformatf("lat3_alu_c%0d", i), 32'({ifb.alu_op, ifb.alu_a, ifb.alu_b}),
                32'({2'd1, 3'b110, 3'b001}));
      check_val($sformatf("lat3_rsp1_c%0d", i), 32'({ifb.rsp1_valid, ifb.rsp0_valid}),
                32'((i == 4) ? 2'b10 : 2'b00));
      check_val($sformatf("lat3_busy_c%0d", i), 32'(ifb.busy), 32'((i <= 4) ? 1 : 0));
      if (i == 4)
        check_val("lat3_rsp", 32'({ifb.rsp_res, ifb.rsp_flags}), 32'({4'b0110, 3'b010}));
      tick();
    end
    ifb.alu_negf = 1'b0;

    // Reset mid-ISSUE with req1 as owner
    ifb.req1_valid = 1'b1; ifb.req1_op = 2'd2; ifb.req1_a = 3'b111; ifb.req1_b = 3'b010;
    ifb.alu_res = 4'b0011;
    @(negedge clk);
    check_val("abort_ready", 32'({ifb.req1_ready, ifb.req0_ready}), 32'd2);
    tick();
    ifb.req1_valid = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 32'(ifb.busy), 32'd1);
    tick();
    rst_b = 1'b1;
    #1;
    check_val("abort_outs", 32'({ifb.busy, ifb.rsp1_valid, ifb.rsp0_valid, ifb.alu_op,
                                 ifb.alu_a, ifb.alu_b, ifb.rsp_res, ifb.rsp_flags}), 32'd0);
    tick();
    rst_b = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifb.rsp1_valid || ifb.rsp0_valid || ifb.busy) pulses++;
      tick();
    end
    check_val("abort_no_rsp", 32'(pulses), 32'd0);
    ifb.req0_valid = 1'b1; ifb.req1_valid = 1'b1;
    @(negedge clk);
    check_val("abort_rr_first", 32'({ifb.req1_ready, ifb.req0_ready}), 32'd1);
    tick();
    ifb.req0_valid = 1'b0; ifb.req1_valid = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
